// File: rtl/ws2811_pkg.sv
// Shared WS2811 definitions: controller state encoding, default chain timing
// and widths used by both the chain controller and the serializer.
package ws2811_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SEND  = 3'd3,
        ST_SHIFT = 3'd4,
        ST_LATCH = 3'd5,
        ST_FIN   = 3'd6
    } ws2811_state_t;

    localparam int DEFAULT_N_LEDS       = 8;
    localparam int DEFAULT_RESET_CYCLES = 2600;  // 52 us at 50 MHz
    localparam int PIXEL_W              = 24;
    localparam int ADDR_W               = 8;
    localparam int LATCH_CNT_W          = 16;

    // The timer reaches zero on the last LATCH cycle, so it is preloaded one short.
    function automatic logic [LATCH_CNT_W-1:0] latch_preload(input int cycles);
        return (cycles > 1) ? LATCH_CNT_W'(cycles - 1) : '0;
    endfunction

endpackage

// File: rtl/ws2811_latch_timer.sv
// Loadable down-counter with a zero flag; times the low period that latches
// the chain after a frame.
module ws2811_latch_timer
    import ws2811_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   load,
    input  logic [LATCH_CNT_W-1:0] load_value,
    output logic                   zero
);

    logic [LATCH_CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counts down to zero and parks there until the next load.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/ws2811_chain_ctrl.sv
// WS2811 chain controller: walks the pixel buffer, sequences the serializer
// one bit at a time, then holds the line low long enough for the LEDs to latch.
module ws2811_chain_ctrl
    import ws2811_pkg::*;
#(
    parameter int N_LEDS       = DEFAULT_N_LEDS,
    parameter int RESET_CYCLES = DEFAULT_RESET_CYCLES
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    output logic [ADDR_W-1:0]  pixel_addr,
    input  logic [PIXEL_W-1:0] pixel_data,
    output logic [PIXEL_W-1:0] rgb_data,
    output logic               load_data,
    output logic               shift_data,
    output logic               send_serial,
    input  logic               fim_bit,
    input  logic               fim_data,
    output logic               busy,
    output logic               done
);

    localparam logic [ADDR_W-1:0]      LAST_IDX      = ADDR_W'(N_LEDS - 1);
    localparam logic [LATCH_CNT_W-1:0] LATCH_PRELOAD = latch_preload(RESET_CYCLES);

    ws2811_state_t     state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              last_bit_q, last_bit_d;
    logic              latch_load;
    logic              latch_zero;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            last_bit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_bit_q <= last_bit_d;
        end
    end

    // Abort is checked first in every active state so it beats fim_bit.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        last_bit_d = last_bit_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = abort ? ST_LATCH : ST_LOAD;
            ST_LOAD:  state_d = abort ? ST_LATCH : ST_SEND;
            ST_SEND: begin
                if (abort) begin
                    state_d = ST_LATCH;
                end else if (fim_bit) begin
                    last_bit_d = fim_data;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d = ST_LATCH;
                end else if (!last_bit_q) begin
                    state_d = ST_SEND;
                end else if (idx_q < LAST_IDX) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (latch_zero) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign latch_load = (state_q != ST_LATCH) && (state_d == ST_LATCH);

    ws2811_latch_timer u_latch_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (latch_load),
        .load_value (LATCH_PRELOAD),
        .zero       (latch_zero)
    );

    // Strobes decode from the state register alone, so reset clears them at once.
    always_comb begin
        load_data   = 1'b0;
        shift_data  = 1'b0;
        send_serial = 1'b0;
        done        = 1'b0;
        busy        = 1'b1;
        case (state_q)
            ST_IDLE:  busy        = 1'b0;
            ST_LOAD:  load_data   = 1'b1;
            ST_SEND:  send_serial = 1'b1;
            ST_SHIFT: shift_data  = 1'b1;
            ST_FIN:   done        = 1'b1;
            default:  ;
        endcase
    end

    assign pixel_addr = idx_q;
    assign rgb_data   = pixel_data;

endmodule
